// File: rtl/esfa_pkg.sv
// Shared definitions for the ESFA command scheduler: command/response field
// layout and the scheduler state encoding.
package esfa_pkg;

  // Command word layout
  localparam int CMD_W            = 48;
  localparam int WILL_WRITE_BIT   = 0;
  localparam int NEW_INDEX_LSB    = 8;
  localparam int NEW_INDEX_W      = 8;
  localparam int NEW_VALUE_LSB    = 16;
  localparam int NEW_VALUE_W      = 8;
  localparam int METADATA_LSB     = 24;
  localparam int METADATA_W       = 8;
  localparam int IS_METADATA_BIT  = 32;
  localparam int SELECTOR_LSB     = 40;
  localparam int SELECTOR_W       = 8;

  // Core response layout (only the low 16 bits carry information)
  localparam int RSP_BOOL_LSB     = 0;
  localparam int RSP_VAL_LSB      = 8;
  localparam int RSP_W            = 8;

  // Scheduler states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage : esfa_pkg

// File: rtl/esfa_rr_arb2.sv
// Two-way round-robin arbiter. Produces a one-hot grant; when both requesters
// are active the one that was not granted last time wins.
module esfa_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] gnt
);

  // Grant selection: single requester wins outright, contention goes to !last_grant
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule : esfa_rr_arb2

// File: rtl/esfa_cmd_scheduler.sv
// Shares one ESFA core between two requesters. One command in flight at a
// time: accept -> drive core bus for one cycle -> wait core latency ->
// capture result -> hold response until the consumer takes it.
module esfa_cmd_scheduler
  import esfa_pkg::*;
#(
  parameter int               CORE_LAT = 1,
  parameter logic [CMD_W-1:0] NOP_CMD  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [CMD_W-1:0] req0_cmd,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [CMD_W-1:0] req1_cmd,
  output logic [CMD_W-1:0] core_cmd,
  input  logic [CMD_W-1:0] core_rsp,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [RSP_W-1:0] rsp_bool,
  output logic [RSP_W-1:0] rsp_value,
  output logic             busy
);

  localparam int            CNT_W    = $clog2(CORE_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_LAT - 1);

  state_e             state_q, state_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic               id_q, id_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RSP_W-1:0]   rsp_bool_q, rsp_bool_d;
  logic [RSP_W-1:0]   rsp_value_q, rsp_value_d;
  logic [1:0]         gnt;

  // Only the low 16 bits of the core response carry the result.
  logic unused_core_rsp;
  assign unused_core_rsp = ^core_rsp[CMD_W-1:RSP_VAL_LSB+RSP_W];

  // Arbitration is only offered in IDLE and never while reset is held.
  esfa_rr_arb2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .enable     ((state_q == IDLE) && !rst),
    .gnt        (gnt)
  );

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      rsp_bool_q   <= '0;
      rsp_value_q  <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rsp_bool_q   <= rsp_bool_d;
      rsp_value_q  <= rsp_value_d;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rsp_bool_d   = rsp_bool_q;
    rsp_value_d  = rsp_value_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          cmd_d        = gnt[1] ? req1_cmd : req0_cmd;
          id_d         = gnt[1];
          last_grant_d = gnt[1];
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_bool_d  = core_rsp[RSP_BOOL_LSB +: RSP_W];
          rsp_value_d = core_rsp[RSP_VAL_LSB +: RSP_W];
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    req0_ready = gnt[0];
    req1_ready = gnt[1];
    rsp_valid  = (state_q == RESP);
    busy       = (state_q != IDLE);
    core_cmd   = (state_q == ISSUE) ? cmd_q : NOP_CMD;
  end

  assign rsp_id    = id_q;
  assign rsp_bool  = rsp_bool_q;
  assign rsp_value = rsp_value_q;

endmodule : esfa_cmd_scheduler

// File: tb/tb_esfa_cmd_scheduler.sv
// Self-checking bench for esfa_cmd_scheduler. Two instances: CORE_LAT=1 with a
// registered core model, and CORE_LAT=3 with a core response that changes
// every cycle. Responses are checked by per-instance scoreboard monitors.
module tb_esfa_cmd_scheduler;

  typedef struct packed {
    logic       id;
    logic [7:0] b;
    logic [7:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  // ---------------- instance 1 (CORE_LAT = 1) ----------------
  logic        r0v1 = 0, r1v1 = 0, rrdy1 = 1;
  logic [47:0] r0c1 = '0, r1c1 = '0, core_rsp1 = '0, core_seen1 = '0;
  logic        r0r1, r1r1, rv1, rid1, busy1;
  logic [47:0] core_cmd1;
  logic [7:0]  rb1, rval1;
  exp_t        q1[$];

  esfa_cmd_scheduler #(.CORE_LAT(1), .NOP_CMD(48'h0)) u_dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(r0v1), .req0_ready(r0r1), .req0_cmd(r0c1),
    .req1_valid(r1v1), .req1_ready(r1r1), .req1_cmd(r1c1),
    .core_cmd(core_cmd1), .core_rsp(core_rsp1),
    .rsp_valid(rv1), .rsp_ready(rrdy1), .rsp_id(rid1),
    .rsp_bool(rb1), .rsp_value(rval1), .busy(busy1)
  );

  // ---------------- instance 3 (CORE_LAT = 3) ----------------
  logic        r0v3 = 0, r1v3 = 0, rrdy3 = 1;
  logic [47:0] r0c3 = '0, r1c3 = '0, core_rsp3 = '0;
  logic        r0r3, r1r3, rv3, rid3, busy3;
  logic [47:0] core_cmd3;
  logic [7:0]  rb3, rval3;
  exp_t        q3[$];

  esfa_cmd_scheduler #(.CORE_LAT(3), .NOP_CMD(48'h0)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(r0v3), .req0_ready(r0r3), .req0_cmd(r0c3),
    .req1_valid(r1v3), .req1_ready(r1r3), .req1_cmd(r1c3),
    .core_cmd(core_cmd3), .core_rsp(core_rsp3),
    .rsp_valid(rv3), .rsp_ready(rrdy3), .rsp_id(rid3),
    .rsp_bool(rb3), .rsp_value(rval3), .busy(busy3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Single-cycle core model: result = {new_value, 7'b0, willWrite}, one cycle after the command.
  always @(negedge clk) core_seen1 = core_cmd1;
  always @(posedge clk) begin
    #1 core_rsp1 = {32'h0, core_seen1[23:16], 7'h0, core_seen1[0]};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor, instance 1
  always @(negedge clk) begin
    if (!rst && rv1 && rrdy1) begin
      if (q1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp1_unexpected: got id=%0d bool=%0h value=%0h expected none", rid1, rb1, rval1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("rsp1_id", 64'(rid1), 64'(e.id));
        check("rsp1_bool", 64'(rb1), 64'(e.b));
        check("rsp1_value", 64'(rval1), 64'(e.v));
      end
    end
  end

  // Scoreboard monitor, instance 3
  always @(negedge clk) begin
    if (!rst && rv3 && rrdy3) begin
      if (q3.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp3_unexpected: got id=%0d bool=%0h value=%0h expected none", rid3, rb3, rval3);
      end else begin
        exp_t e;
        e = q3.pop_front();
        check("rsp3_id", 64'(rid3), 64'(e.id));
        check("rsp3_bool", 64'(rb3), 64'(e.b));
        check("rsp3_value", 64'(rval3), 64'(e.v));
      end
    end
  end

  // Wait (bounded) for a specific requester of instance 1 to be accepted.
  task automatic wait_accept(input int which, output int acc);
    logic found = 1'b0;
    acc = -1;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if ((which == 0) ? r0r1 : r1r1) begin
        found = 1'b1;
        acc = cyc;
      end
    end
    check($sformatf("accept_req%0d_seen", which), 64'(found), 64'd1);
  endtask

  // Wait (bounded) for either requester of instance 1 to be accepted.
  task automatic wait_any_accept(output int who, output int acc);
    logic found = 1'b0;
    who = -1;
    acc = -1;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (r0r1 || r1r1) begin
        found = 1'b1;
        acc = cyc;
        who = r1r1 ? 1 : 0;
        check("ready_onehot", 64'(r0r1 & r1r1), 64'd0);
      end
    end
    check("accept_any_seen", 64'(found), 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  logic [47:0] rr_cmd [4];
  exp_t        rr_exp [4];
  int          rr_who [4];
  logic [15:0] rsp_tab [1:6];

  initial begin
    int t, who, prev, hs;
    logic seen;
    rr_cmd[0] = 48'hA1_01_77_5C_07_01; rr_exp[0] = '{id: 1'b0, b: 8'h01, v: 8'h5C}; rr_who[0] = 0;
    rr_cmd[1] = 48'hB2_00_10_C3_09_00; rr_exp[1] = '{id: 1'b1, b: 8'h00, v: 8'hC3}; rr_who[1] = 1;
    rr_cmd[2] = 48'h03_00_00_99_01_FF; rr_exp[2] = '{id: 1'b0, b: 8'h01, v: 8'h99}; rr_who[2] = 0;
    rr_cmd[3] = 48'h00_FE_00_01_FF_02; rr_exp[3] = '{id: 1'b1, b: 8'h00, v: 8'h01}; rr_who[3] = 1;
    rsp_tab[1] = 16'h1101; rsp_tab[2] = 16'h2202; rsp_tab[3] = 16'h3303;
    rsp_tab[4] = 16'h4404; rsp_tab[5] = 16'h5505; rsp_tab[6] = 16'h6606;

    // ---- 1: reset with both requesters valid ----
    rst = 1; r0v1 = 1; r1v1 = 1; r0c1 = 48'h1; r1c1 = 48'h2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_req0_ready", 64'(r0r1), 64'd0);
      check("rst_req1_ready", 64'(r1r1), 64'd0);
      check("rst_rsp_valid", 64'(rv1), 64'd0);
      check("rst_busy", 64'(busy1), 64'd0);
      check("rst_core_cmd", 64'(core_cmd1), 64'h0);
    end

    // ---- 2: single command, CORE_LAT=1 ----
    @(posedge clk); #1;
    rst = 0; r1v1 = 0; r0v1 = 1; r0c1 = 48'h0000_002A_0501; rrdy1 = 1;
    wait_accept(0, t);
    check("t2_req1_ready", 64'(r1r1), 64'd0);
    q1.push_back('{id: 1'b0, b: 8'h01, v: 8'h2A});
    @(posedge clk); #1 r0v1 = 0;
    @(negedge clk);
    check("t2_core_cmd_T1", 64'(core_cmd1), 64'h0000_002A_0501);
    check("t2_busy_T1", 64'(busy1), 64'd1);
    check("t2_ready_T1", 64'(r0r1), 64'd0);
    @(negedge clk);
    check("t2_core_cmd_T2", 64'(core_cmd1), 64'h0);
    check("t2_rsp_valid_T2", 64'(rv1), 64'd0);
    @(negedge clk);
    check("t2_rsp_valid_T3", 64'(rv1), 64'd1);
    @(negedge clk);
    check("t2_rsp_valid_T4", 64'(rv1), 64'd0);
    check("t2_busy_T4", 64'(busy1), 64'd0);

    // ---- 3: round-robin with both requesters valid after reset ----
    @(posedge clk); #1;
    rst = 1; r0v1 = 1; r1v1 = 1; r0c1 = rr_cmd[0]; r1c1 = rr_cmd[1];
    @(posedge clk); #1 rst = 0;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      wait_any_accept(who, t);
      check($sformatf("t3_grant%0d_who", k), 64'(who), 64'(rr_who[k]));
      if (prev >= 0) check($sformatf("t3_grant%0d_interval", k), 64'(t - prev), 64'd4);
      prev = t;
      q1.push_back(rr_exp[k]);
      @(posedge clk); #1;
      if (who == 0) begin
        if (k + 2 < 4) r0c1 = rr_cmd[k+2]; else r0v1 = 0;
      end else begin
        if (k + 2 < 4) r1c1 = rr_cmd[k+2]; else r1v1 = 0;
      end
      @(negedge clk);
      check($sformatf("t3_core_cmd%0d", k), 64'(core_cmd1), 64'(rr_cmd[k]));
    end
    r0v1 = 0; r1v1 = 0;
    idle_cycles(6);

    // ---- 4: consumer back-pressure in RESP ----
    rrdy1 = 0; r0v1 = 1; r0c1 = 48'h00_00_00_6E_00_01;
    wait_accept(0, t);
    q1.push_back('{id: 1'b0, b: 8'h01, v: 8'h6E});
    @(posedge clk); #1;
    r0v1 = 0; r1v1 = 1; r1c1 = 48'h11_22_33_44_55_66;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rv1) seen = 1'b1;
    end
    check("t4_rsp_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("t4_hold_valid", 64'(rv1), 64'd1);
      check("t4_hold_id", 64'(rid1), 64'd0);
      check("t4_hold_bool", 64'(rb1), 64'h01);
      check("t4_hold_value", 64'(rval1), 64'h6E);
      check("t4_hold_ready0", 64'(r0r1), 64'd0);
      check("t4_hold_ready1", 64'(r1r1), 64'd0);
    end
    @(posedge clk); #1 rrdy1 = 1;
    @(negedge clk);
    check("t4_hs_valid", 64'(rv1), 64'd1);
    check("t4_hs_ready1", 64'(r1r1), 64'd0);
    hs = cyc;
    wait_accept(1, t);
    check("t4_accept_after_hs", 64'(t - hs), 64'd1);
    q1.push_back('{id: 1'b1, b: 8'h00, v: 8'h44});
    @(posedge clk); #1 r1v1 = 0;
    idle_cycles(6);

    // ---- 5: reset while waiting on the core ----
    r0v1 = 1; r0c1 = 48'hFF_FF_FF_FF_FF_FF;
    wait_accept(0, t);
    @(posedge clk); #1 r0v1 = 0;
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    check("t5_busy_in_wait", 64'(busy1), 64'd1);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_rsp", 64'(rv1), 64'd0);
      check("t5_idle", 64'(busy1), 64'd0);
      check("t5_core_nop", 64'(core_cmd1), 64'h0);
    end
    @(posedge clk); #1;
    r1v1 = 1; r1c1 = 48'h00_00_00_B7_00_03;
    wait_accept(1, t);
    q1.push_back('{id: 1'b1, b: 8'h01, v: 8'hB7});
    @(posedge clk); #1 r1v1 = 0;
    idle_cycles(6);

    // ---- 6: CORE_LAT=3, core response changes every cycle ----
    r0v3 = 1; r0c3 = 48'h00_00_00_12_34_01; rrdy3 = 1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (r0r3) seen = 1'b1;
    end
    check("t6_accept_seen", 64'(seen), 64'd1);
    q3.push_back('{id: 1'b0, b: 8'h04, v: 8'h44});
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      core_rsp3 = {32'hDEAD_BEEF, rsp_tab[k]};
      if (k == 1) r0v3 = 0;
      @(negedge clk);
      if (k == 1) check("t6_core_cmd_T1", 64'(core_cmd3), 64'h00_00_00_12_34_01);
      if (k == 2) check("t6_core_cmd_T2", 64'(core_cmd3), 64'h0);
      check($sformatf("t6_rsp_valid_T%0d", k), 64'(rv3), 64'(k == 5));
    end
    idle_cycles(3);

    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q3_drained", 64'(q3.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_esfa_cmd_scheduler
